div_unit: RTL and testbench



---
 rtl/div_unit_pkg.sv | 31 +++
 rtl/div_unit.sv | 160 ++++++++++++++++
 tb/tb_div_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32M iterative divide/remainder unit.
// Operation and state encodings plus datapath sizing constants.
package div_unit_pkg;

  localparam int INSTRUCTION_SIZE = 32;
  localparam int REG_COUNT        = 32;
  localparam int DIV_LATENCY      = INSTRUCTION_SIZE + 2;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/div_unit.sv
// Restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_FASTPATH_EN lets trivial cases skip the iteration phase.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN      = INSTRUCTION_SIZE,
  parameter int REG_IDX_W = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [REG_IDX_W-1:0] rd_in,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  output logic                 busy,
  output logic                 done,
  output logic [XLEN-1:0]      result,
  output logic [REG_IDX_W-1:0] rd_out
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  div_state_e           state_q, state_d;
  div_op_e              op_q;
  logic [REG_IDX_W-1:0] rd_q;
  logic [XLEN-1:0]      dvs_q;
  logic [XLEN-1:0]      rem_q;
  logic [XLEN-1:0]      quo_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 neg_quo_q;
  logic                 neg_rem_q;
  logic                 div_zero_q;
  logic [XLEN-1:0]      result_q;
  logic [REG_IDX_W-1:0] rd_out_q;

  div_op_e         op_in;
  logic            in_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            b_zero;
  logic            accept;
  logic            fast;
  logic [XLEN-1:0] fast_quo;
  logic [XLEN-1:0] fast_rem;

  assign op_in     = div_op_e'(op);
  assign in_signed = op_is_signed(op_in);
  assign a_neg     = in_signed & rs1_data[XLEN-1];
  assign b_neg     = in_signed & rs2_data[XLEN-1];
  assign a_abs     = a_neg ? (-rs1_data) : rs1_data;
  assign b_abs     = b_neg ? (-rs2_data) : rs2_data;
  assign b_zero    = (rs2_data == '0);
  assign accept    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

`ifdef DIV_FASTPATH_EN
  // Preload the magnitudes FIX expects so sign correction stays shared.
  logic overflow;
  assign overflow = in_signed && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
  assign fast     = b_zero || overflow || (a_abs < b_abs);
  always_comb begin
    fast_quo = '0;
    fast_rem = a_abs;
    if (b_zero) begin
      fast_quo = '1;
    end else if (overflow) begin
      fast_quo = a_abs;
      fast_rem = '0;
    end
  end
`else
  assign fast     = 1'b0;
  assign fast_quo = '0;
  assign fast_rem = '0;
`endif

  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            fits;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;

  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign fits    = ~diff[XLEN];
  assign rem_nxt = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_nxt = {quo_q[XLEN-2:0], fits};

  logic [XLEN-1:0] quo_signed;
  logic [XLEN-1:0] rem_signed;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] fix_result;

  // Divide-by-zero quotient is all ones regardless of operand signs.
  assign quo_signed = neg_quo_q ? (-quo_q) : quo_q;
  assign rem_signed = neg_rem_q ? (-rem_q) : rem_q;
  assign quotient   = div_zero_q ? '1 : quo_signed;
  assign fix_result = op_is_rem(op_q) ? rem_signed : quotient;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = fast ? ST_FIX : ST_CALC;
      ST_CALC: if (cnt_q == CNT_LAST) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: begin
        if (accept) state_d = fast ? ST_FIX : ST_CALC;
        else        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= DIV_OP_DIV;
      rd_q       <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      result_q   <= '0;
      rd_out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q       <= op_in;
        rd_q       <= rd_in;
        dvs_q      <= b_abs;
        quo_q      <= fast ? fast_quo : a_abs;
        rem_q      <= fast ? fast_rem : '0;
        cnt_q      <= '0;
        neg_quo_q  <= a_neg ^ b_neg;
        neg_rem_q  <= a_neg;
        div_zero_q <= b_zero;
      end else if (state_q == ST_CALC) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == ST_FIX) begin
        result_q <= fix_result;
        rd_out_q <= rd_q;
      end
    end
  end

  assign busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit with hand-computed expectations.
// Expected latencies follow DIV_FASTPATH_EN when it is defined.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  rd_in;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int errors = 0;
  int checks = 0;

`ifdef DIV_FASTPATH_EN
  localparam int FAST_LAT = 2;
`else
  localparam int FAST_LAT = DIV_LATENCY;
`endif

  div_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .rd_in    (rd_in),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rd_out   (rd_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Holds start for exactly one rising edge; callers are always off-edge.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd);
    op       = o;
    rs1_data = a;
    rs2_data = b;
    rd_in    = rd;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int from, output int lat);
    lat = from;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp_res, input int exp_lat);
    int lat;
    applyStimulus(o, a, b, rd);
    waitDone(1, lat);
    checkOutput({tag, " result"}, result, exp_res);
    checkOutput({tag, " rd_out"}, {27'b0, rd_out}, {27'b0, rd});
    checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int lat;
    int pulses;
    rst      = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    rd_in    = '0;
    rs1_data = '0;
    rs2_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset done", {31'b0, done}, 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset rd_out", {27'b0, rd_out}, 32'd0);
    rst = 1'b0;

    applyStimulus(DIV_OP_DIVU, 32'd100, 32'd7, 5'd3);
    checkOutput("divu busy", {31'b0, busy}, 32'd1);
    waitDone(1, lat);
    checkOutput("divu 100/7 result", result, 32'h0000000E);
    checkOutput("divu 100/7 rd_out", {27'b0, rd_out}, 32'd3);
    checkOutput("divu 100/7 latency", 32'(lat), 32'd34);
    checkOutput("done busy low", {31'b0, busy}, 32'd0);

    runOp("remu 100/7", DIV_OP_REMU, 32'd100, 32'd7, 5'd4, 32'h00000002, 34);
    runOp("div -7/2", DIV_OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, 34);
    runOp("rem -7/2", DIV_OP_REM, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 34);
    runOp("divu 5/0", DIV_OP_DIVU, 32'd5, 32'd0, 5'd10, 32'hFFFFFFFF, FAST_LAT);
    runOp("remu 5/0", DIV_OP_REMU, 32'd5, 32'd0, 5'd11, 32'h00000005, FAST_LAT);
    runOp("div ovf", DIV_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, FAST_LAT);
    runOp("rem ovf", DIV_OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000, FAST_LAT);
    runOp("div -7/0", DIV_OP_DIV, 32'hFFFFFFF9, 32'd0, 5'd14, 32'hFFFFFFFF, FAST_LAT);

    // A start pulse while busy must not disturb the running operation.
    applyStimulus(DIV_OP_DIVU, 32'd50, 32'd5, 5'd7);
    lat = 1;
    repeat (9) begin
      @(posedge clk);
      #1;
      lat++;
    end
    op       = DIV_OP_DIVU;
    rs1_data = 32'd9;
    rs2_data = 32'd3;
    rd_in    = 5'd9;
    start    = 1'b1;
    @(posedge clk);
    #1;
    lat++;
    start = 1'b0;
    checkOutput("ignore busy", {31'b0, busy}, 32'd1);
    waitDone(lat, lat);
    checkOutput("ignore result", result, 32'h0000000A);
    checkOutput("ignore rd_out", {27'b0, rd_out}, 32'd7);
    checkOutput("ignore latency", 32'(lat), 32'd34);

    applyStimulus(DIV_OP_DIVU, 32'd9, 32'd3, 5'd9);
    checkOutput("b2b busy", {31'b0, busy}, 32'd1);
    waitDone(1, lat);
    checkOutput("b2b result", result, 32'h00000003);
    checkOutput("b2b rd_out", {27'b0, rd_out}, 32'd9);
    checkOutput("b2b latency", 32'(lat), 32'd34);

    applyStimulus(DIV_OP_DIV, 32'd1000, 32'd3, 5'd15);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort busy", {31'b0, busy}, 32'd0);
    checkOutput("abort done", {31'b0, done}, 32'd0);
    checkOutput("abort result", result, 32'd0);
    checkOutput("abort rd_out", {27'b0, rd_out}, 32'd0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    checkOutput("abort no done", 32'(pulses), 32'd0);

    runOp("divu 3/10", DIV_OP_DIVU, 32'd3, 32'd10, 5'd20, 32'h00000000, FAST_LAT);
    runOp("rem -3/10", DIV_OP_REM, 32'hFFFFFFFD, 32'd10, 5'd21, 32'hFFFFFFFD, FAST_LAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
